// File: rtl/led_matrix_scan_if.sv
// Write/swap bus and LED pin bundle for the 8x8 row-multiplexed matrix driver.
interface led_matrix_scan_if;
    logic       we;
    logic [2:0] w_row;
    logic [7:0] w_data;
    logic       swap_req;
    logic [7:0] row;
    logic [7:0] col;
    logic       frame_done;
    logic       swap_pending;

    modport master (
        output we, w_row, w_data, swap_req,
        input  row, col, frame_done, swap_pending
    );

    modport slave (
        input  we, w_row, w_data, swap_req,
        output row, col, frame_done, swap_pending
    );
endinterface

// File: rtl/led_matrix_scan.sv
// 8x8 LED matrix scanner: double-buffered frame, blank/drive row multiplexing,
// swaps between front and back buffer only at frame boundaries.
module led_matrix_scan #(
    parameter int unsigned DWELL = 1024,
    parameter int unsigned BLANK = 16
) (
    input  logic             clk,
    input  logic             rst,
    led_matrix_scan_if.slave bus
);
    localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_ridx, w_ridx_nxt;
    logic             r_sel, w_sel_nxt;
    logic             r_pending, w_pending_nxt;
    logic [7:0]       r_row, w_row_nxt;
    logic [7:0]       r_col, w_col_nxt;
    logic             r_frame_done, w_frame_done_nxt;
    logic             w_frame_end;
    logic [7:0]       r_buf [2][8];

    // Next-state, swap arbitration and next pin values
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + CNT_W'(1);
        w_ridx_nxt       = r_ridx;
        w_sel_nxt        = r_sel;
        w_pending_nxt    = r_pending;
        w_row_nxt        = 8'h00;
        w_col_nxt        = 8'hFF;
        w_frame_end      = (r_state == S_DRIVE) && (r_cnt == DWELL_LAST) && (r_ridx == 3'd7);
        w_frame_done_nxt = w_frame_end;

        case (r_state)
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRIVE: begin
                w_row_nxt = 8'h01 << r_ridx;
                w_col_nxt = ~r_buf[r_sel][r_ridx];
                if (r_cnt == DWELL_LAST) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_ridx_nxt  = 3'(r_ridx + 3'd1);
                end
            end
            default: begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase

        // A request landing on the frame-end cycle is honoured immediately
        if (w_frame_end) begin
            if (r_pending || bus.swap_req) begin
                w_sel_nxt = ~r_sel;
            end
            w_pending_nxt = 1'b0;
        end else if (bus.swap_req) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_BLANK;
            r_cnt        <= '0;
            r_ridx       <= 3'd0;
            r_sel        <= 1'b0;
            r_pending    <= 1'b0;
            r_row        <= 8'h00;
            r_col        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ridx       <= w_ridx_nxt;
            r_sel        <= w_sel_nxt;
            r_pending    <= w_pending_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Writes always target the current back buffer, even on the swap cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    r_buf[b][r] <= 8'h00;
                end
            end
        end else if (bus.we) begin
            r_buf[~r_sel][bus.w_row] <= bus.w_data;
        end
    end

    assign bus.row          = r_row;
    assign bus.col          = r_col;
    assign bus.frame_done   = r_frame_done;
    assign bus.swap_pending = r_pending;
endmodule
